// File: rtl/sport_tx_pkg.sv
// sport_tx_pkg: shared types, defaults and helpers for the SPORT
// multichannel transmitter (sport_tx_mc, sport_tx_fifo).
package sport_tx_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 4;
  localparam int NCH_DEF   = 32;
  localparam int CW_DEF    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit of the shift register that drives TD.
  function automatic int td_idx(
    input int   slen,
    input logic msbf
  );
    return msbf ? slen : 0;
  endfunction

endpackage

// File: rtl/sport_tx_fifo.sv
// sport_tx_fifo: synchronous transmit FIFO, no write-to-read bypass.
// Ports: clk, rst (sync high), flush, wr/wdata, rd/rdata, full, empty, count.
module sport_tx_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_ok;
  logic          wr_ok;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // A pop frees the slot this edge, so a
  // write alongside it is accepted when full.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/sport_tx_mc.sv
// sport_tx_mc: multichannel SPORT transmitter, FIFO-buffered, framed by TFS.
// Ports: DSPCLK/RST, SP_EN, SCLK_EN, TFS, SLEN, MWORD, CH_MASK, MSBF,
//        TX_WE/TX_DI, UNDER_CLR -> TX_FULL, TSREQ, TD, TD_OE, IST,
//        SLOT_NUM, UNDERRUN.
module sport_tx_mc
  import sport_tx_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int NCH   = NCH_DEF,
  parameter  int CW    = CW_DEF,
  localparam int BW    = $clog2(DW),
  localparam int SW    = $clog2(NCH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           DSPCLK,
  input  logic           RST,
  input  logic           SP_EN,
  input  logic           SCLK_EN,
  input  logic           TFS,
  input  logic [BW-1:0]  SLEN,
  input  logic [CW-1:0]  MWORD,
  input  logic [NCH-1:0] CH_MASK,
  input  logic           MSBF,
  input  logic           TX_WE,
  input  logic [DW-1:0]  TX_DI,
  input  logic           UNDER_CLR,
  output logic           TX_FULL,
  output logic           TSREQ,
  output logic           TD,
  output logic           TD_OE,
  output logic           IST,
  output logic [SW-1:0]  SLOT_NUM,
  output logic           UNDERRUN
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  state_t        state;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] slot;
  logic [DW-1:0] shreg;
  logic          oe_q;
  logic          ist_q;
  logic          under_q;

  logic          f_wr;
  logic          f_rd;
  logic          f_full;
  logic          f_empty;
  logic [DW-1:0] f_rdata;
  logic [AW:0]   f_count;

  logic          in_shift;
  logic          word_end;
  logic          frame_end;
  logic          start;
  logic          next_w;
  logic          ld;
  logic [CW-1:0] slot_ld;
  logic          slot_on;
  logic          under_set;
  logic [BW-1:0] idx;

  sport_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (DSPCLK),
    .rst   (RST),
    .flush (!SP_EN),
    .wr    (f_wr),
    .wdata (TX_DI),
    .rd    (f_rd),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign f_wr = TX_WE && SP_EN;

  always_comb begin
    in_shift  = (state == SHIFT);
    word_end  = in_shift && (bcnt == '0);
    frame_end = word_end && (wcnt == '0);
    // A frame can start from IDLE or chain off the
    // last bit of the previous frame, nowhere else.
    start     = SP_EN && SCLK_EN && TFS &&
                (!in_shift || frame_end);
    next_w    = SP_EN && SCLK_EN && word_end &&
                (wcnt != '0);
    ld        = start || next_w;
    slot_ld   = start ? '0 : slot + C_ONE;
    slot_on   = (int'(slot_ld) < NCH) &&
                CH_MASK[slot_ld[SW-1:0]];
    f_rd      = ld && slot_on;
    under_set = ld && slot_on && f_empty;
    idx       = BW'(td_idx(int'(SLEN), MSBF));
  end

  always_ff @(posedge DSPCLK) begin
    if (RST || !SP_EN) begin
      state <= IDLE;
      bcnt  <= '0;
      wcnt  <= '0;
      slot  <= '0;
      shreg <= '0;
      oe_q  <= 1'b0;
      ist_q <= 1'b0;
    end else begin
      ist_q <= start;
      if (ld) begin
        state <= SHIFT;
        bcnt  <= SLEN;
        wcnt  <= start ? MWORD : wcnt - C_ONE;
        slot  <= slot_ld;
        shreg <= (slot_on && !f_empty) ? f_rdata : '0;
        oe_q  <= slot_on;
      end else if (SCLK_EN && in_shift) begin
        if (frame_end) begin
          state <= IDLE;
          bcnt  <= '0;
          wcnt  <= '0;
          slot  <= '0;
          shreg <= '0;
          oe_q  <= 1'b0;
        end else begin
          bcnt  <= bcnt - B_ONE;
          shreg <= MSBF ? (shreg << 1) : (shreg >> 1);
        end
      end
    end
  end

  // Underrun survives SP_EN=0; set beats clear.
  always_ff @(posedge DSPCLK) begin
    if (RST)            under_q <= 1'b0;
    else if (under_set) under_q <= 1'b1;
    else if (UNDER_CLR) under_q <= 1'b0;
  end

  assign TD       = in_shift ? shreg[idx] : 1'b0;
  assign TD_OE    = in_shift && oe_q;
  assign SLOT_NUM = in_shift ? slot[SW-1:0] : '0;
  assign IST      = ist_q;
  assign TX_FULL  = (f_count == DEPTH_C);
  assign TSREQ    = SP_EN && !f_full;
  assign UNDERRUN = under_q;

endmodule

// File: doc/sport_tx_mc.md
Name: sport_tx_mc

Overview:
- Parametrised multichannel serial-port transmit controller.
- Buffers DSP-side words in a small FIFO and serialises them onto TD in frames started by a frame sync.
- Supports programmable word length, programmable words per frame, a per-slot channel enable mask, and MSB/LSB-first order.
- Runs entirely in the DSPCLK domain; the serial clock is presented as a one-cycle enable (SCLK_EN).

Parameters:
- DW, 16: maximum serial word width in bits (power of 2, 8..32).
- DEPTH, 4: transmit FIFO depth in words (power of 2, 2..16).
- NCH, 32: maximum slots per frame; size of the channel mask.
- CW, 8: width of the word counter and MWORD (must satisfy 2^CW >= NCH).

Ports:
- DSPCLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- SP_EN  in  1  port enable; low synchronously forces idle and flushes the FIFO.
- SCLK_EN  in  1  serial bit-time strobe; one DSPCLK wide.
- TFS  in  1  frame sync; sampled only when SCLK_EN=1.
- SLEN  in  $clog2(DW)  word length minus 1.
- MWORD  in  CW  words per frame minus 1.
- CH_MASK  in  NCH  bit n=1 means slot n is transmitted.
- MSBF  in  1  1 = MSB first, 0 = LSB first.
- TX_WE  in  1  FIFO write strobe.
- TX_DI  in  DW  FIFO write data; bits above SLEN are ignored on output.
- UNDER_CLR  in  1  clears UNDERRUN.
- TX_FULL  out  1  FIFO full.
- TSREQ  out  1  service request; level.
- TD  out  1  serial data.
- TD_OE  out  1  TD drive enable.
- IST  out  1  frame-start interrupt; one DSPCLK pulse.
- SLOT_NUM  out  $clog2(NCH)  slot currently shifting.
- UNDERRUN  out  1  sticky underrun flag.

Behaviour:
- Reset: FSM=IDLE, FIFO empty, shift register=0, bit count=0, word count=0, slot=0. Outputs: TD=0, TD_OE=0, IST=0, TSREQ=0, TX_FULL=0, UNDERRUN=0, SLOT_NUM=0.
- FSM states: IDLE and SHIFT. The FSM advances only on cycles with SCLK_EN=1, except the SP_EN/RST override below.
- IDLE -> SHIFT when SCLK_EN && TFS && SP_EN. On that edge:
  - bcnt <= SLEN, wcnt <= MWORD, slot <= 0.
  - Slot 0 is loaded (load rule below).
  - IST=1 for the following single DSPCLK cycle.
- SHIFT, bcnt != 0, on each tick:
  - bcnt decrements.
  - Shift register moves one bit toward the output position (left if MSBF=1, right if MSBF=0), zero-filled.
- SHIFT, bcnt == 0, on a tick:
  - If wcnt != 0: wcnt decrements, slot increments, bcnt <= SLEN, next slot is loaded. There is no gap bit; words are back to back.
  - If wcnt == 0 and TFS == 1: start a new frame, same actions as IDLE -> SHIFT, IST pulses.
  - If wcnt == 0 and TFS == 0: go to IDLE.
- TFS seen while in SHIFT with bcnt != 0 or wcnt != 0 is ignored.
- Slot load rule, slot s:
  - s >= NCH: treated as disabled.
  - CH_MASK[s]=1 and FIFO not empty: pop one word into the shift register.
  - CH_MASK[s]=1 and FIFO empty: load zeros, set UNDERRUN, TD_OE stays 1.
  - CH_MASK[s]=0: no pop, shift register cleared, TD_OE=0 for the whole slot.
- TD output:
  - MSBF=1: TD = shreg[SLEN]; MSBF=0: TD = shreg[0].
  - TD is combinational from registered state and changes in the cycle after the tick.
  - In IDLE: TD=0, TD_OE=0.
- SLOT_NUM is the low $clog2(NCH) bits of the slot counter; it is 0 in IDLE.
- FIFO write: a write with TX_WE while full is dropped; FIFO contents are unchanged.
- Simultaneous write and pop: both happen and the count is unchanged.
- Write into an empty FIFO on the same cycle as a pop: the pop sees empty (no bypass) and underrun is flagged; the written word is kept.
- TX_FULL = (count == DEPTH). TSREQ = SP_EN && !TX_FULL.
- UNDERRUN: set by an underrun, cleared by UNDER_CLR; set wins if both occur on the same cycle.
- SP_EN=0 (any cycle, not gated by SCLK_EN):
  - Next edge: FSM=IDLE, FIFO flushed, bcnt/wcnt/slot=0.
  - UNDERRUN is kept; TX_WE is ignored while SP_EN=0.
- SLEN, MWORD, MSBF and CH_MASK are sampled live. Software changes them only while SP_EN=0; behaviour under mid-frame changes is undefined.

Decomposition:
- Package sport_tx_pkg holds:
  - the state enum (IDLE, SHIFT);
  - default DW/DEPTH/NCH/CW;
  - a function computing the output bit index from SLEN/MSBF.
- One sub-module, sport_tx_fifo: synchronous FIFO with parameters DW and DEPTH; ports wr/rd/flush, full/empty/count; no bypass.

Test Plan:
- Single word: SLEN=7, MWORD=0, MSBF=1, CH_MASK=1, write 0xA5, pulse TFS with a tick every 4 clocks:
  - TD = 1,0,1,0,0,1,0,1 over 8 ticks; IST pulses once; FSM returns to IDLE; TSREQ stays 1.
- LSB-first, three words: SLEN=3, MWORD=2, MSBF=0, write 0x1, 0x2, 0x4:
  - TD = 1000 0100 0010 back to back; SLOT_NUM steps 0, 1, 2; FIFO empty at end.
- Channel mask: MWORD=3, CH_MASK=0b0101, write 0x11, 0x22:
  - Slots 0 and 2 carry the words with TD_OE=1; slots 1 and 3 have TD_OE=0; no pops occur for slots 1 and 3.
- Underrun: MWORD=1, one word written:
  - Slot 1 shifts zeros; UNDERRUN=1 until UNDER_CLR; set-vs-clear on the same cycle leaves UNDERRUN=1.
- FIFO full (DEPTH=4): write 5 words:
  - TX_FULL=1 and TSREQ=0 after the 4th write; 5th word dropped; a pop with a write on the same cycle keeps TX_FULL=1.
- Mid-frame disable: drop SP_EN during bit 3 of a 16-bit word:
  - Next edge: IDLE, TD_OE=0, FIFO empty.
  - Re-enabling plus TFS starts a clean frame with IST.
  - Also check TFS on the last bit of a frame chains directly into the next frame.
